axis_cpu_dispatch: RTL and testbench
====================================

Name: axis_cpu_dispatch

Overview:
Packet scheduler that shares a pool of N axis_cpu instances between one input packet stream and one output packet stream. Each TLAST-delimited input packet goes to a CPU lane with free credit, chosen round-robin. The lane index is recorded in an order FIFO. Output packets are collected from the lanes strictly in dispatch order, so packet order is preserved end to end. Sits between the network-facing AXIS ports and an array of axis_cpu din/dout ports.

Parameters:
N_CPUS, 4, number of axis_cpu lanes (2..16)
IDX_WIDTH, 2, lane index width; must equal clog2(N_CPUS), minimum 1
ORDER_DEPTH_LOG2, 4, log2 depth of the order FIFO (16 entries)
MAX_OUTSTANDING, 2, maximum packets in flight per lane (1..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
din_TDATA  in  32  input packet data
din_TVALID  in  1  input valid
din_TREADY  out  1  input ready
din_TLAST  in  1  input end of packet
cpu_din_TDATA  out  32*N_CPUS  per-lane data to CPU din; lane i at bits [32i+31:32i]
cpu_din_TVALID  out  N_CPUS  per-lane valid
cpu_din_TREADY  in  N_CPUS  per-lane ready
cpu_din_TLAST  out  N_CPUS  per-lane last
cpu_dout_TDATA  in  32*N_CPUS  per-lane CPU result data
cpu_dout_TVALID  in  N_CPUS  per-lane result valid
cpu_dout_TREADY  out  N_CPUS  per-lane result ready
cpu_dout_TLAST  in  N_CPUS  per-lane result last
dout_TDATA  out  32  collected output data
dout_TVALID  out  1  output valid
dout_TREADY  in  1  output ready
dout_TLAST  out  1  output last

Behaviour:
- Reset is asynchronous and active-high.
  - Reset clears: rr_ptr=0, lock=0, sel_lane=0, credit[i]=0, FIFO empty.
  - While rst=1, every handshake output is 0: din_TREADY, cpu_din_TVALID, cpu_dout_TREADY, dout_TVALID.
  - Reset mid-packet abandons the packet. No recovery is attempted; the system reprograms and flushes the CPUs.
- Contract: each dispatched packet yields exactly one output packet on the same lane.
- Dispatch FSM has two states, IDLE and LOCKED.
  - IDLE, candidate lane: the first lane i, scanning rr_ptr, rr_ptr+1, ... modulo N_CPUS, with credit[i] < MAX_OUTSTANDING. The candidate exists only if the order FIFO is not full.
  - IDLE with a candidate c: din is routed combinationally to lane c.
    - cpu_din_TVALID[c] = din_TVALID.
    - din_TREADY = cpu_din_TREADY[c].
    - All other lanes have TVALID=0.
  - IDLE with no candidate: din_TREADY=0.
  - First-beat handshake on lane c:
    - Push c into the FIFO.
    - credit[c] increments.
    - rr_ptr becomes c+1, wrapping at N_CPUS.
    - If din_TLAST=0, go to LOCKED with sel_lane=c. If TLAST=1 (single-beat packet), stay in IDLE.
  - LOCKED: din is routed to sel_lane regardless of credit or FIFO state. The TLAST handshake returns the FSM to IDLE.
  - cpu_din_TDATA and cpu_din_TLAST are broadcast to all lanes; only TVALID is per-lane.
- Collector:
  - FIFO empty: dout_TVALID=0 and all cpu_dout_TREADY=0.
  - FIFO not empty, head h:
    - dout_TDATA, dout_TVALID and dout_TLAST come from lane h.
    - cpu_dout_TREADY[h] = dout_TREADY.
    - All other lanes see TREADY=0, so their results wait.
  - A TLAST handshake on dout pops the FIFO and decrements credit[h].
- Latency is zero cycles in both directions (combinational pass-through). The only registered state is the FSM, rr_ptr, credits and FIFO.
- Simultaneous events:
  - Dispatch-push and collect-pop in the same cycle are both performed. FIFO count is unchanged.
  - If both hit the same lane, credit is unchanged.
  - A FIFO that is full with a pop this cycle still refuses the push. The full flag is registered, which avoids a combinational pop-to-push path.
- Credits are 3 bits wide. A credit never exceeds MAX_OUTSTANDING and never underflows. A pop with credit=0 is a contract violation and is guarded by an assertion.

Decomposition:
- Shared package/header axis_cpu_dispatch_pkg holds the FSM state encodings (DISP_IDLE=0, DISP_LOCKED=1) and the credit width constant.
- One sub-module: axis_cpu_order_fifo.
  - Synchronous FIFO, IDX_WIDTH wide, 2^ORDER_DEPTH_LOG2 deep.
  - Ports: push, pop, din, dout (head), registered full and empty flags.
  - Asynchronous reset.

Test Plan:
- 4 single-beat packets on an idle pool, dout_TREADY=1 -> lanes 0,1,2,3 each receive one beat; outputs are emitted in order 0,1,2,3; FIFO is empty at end.
- Lane 1 result delayed 50 cycles while lanes 2 and 3 finish early -> dout stalls until lane 1's TLAST, then emits lanes 2 and 3; cpu_dout_TREADY[2] and [3] stay 0 during the wait.
- MAX_OUTSTANDING=2, N=4, dout_TREADY=0 -> 8 packets are accepted; the 9th first beat sees din_TREADY=0 until one output TLAST handshakes.
- 5-beat packet to lane 2, with lane 2 dropping TREADY for 3 cycles mid-packet -> din_TREADY follows it; no beat leaks to other lanes; FSM returns to IDLE after TLAST.
- Push and pop of the same lane in the same cycle -> credit stays at 1 and FIFO count is unchanged.
- rst asserted mid-packet on a LOCKED lane -> all valid/ready outputs drop to 0 immediately; after release rr_ptr=0 and the next packet goes to lane 0.

Source files
------------

// File: rtl/axis_cpu_dispatch_pkg.sv
// rtl/axis_cpu_dispatch_pkg.sv - shared types and constants for the axis_cpu packet dispatcher
package axis_cpu_dispatch_pkg;

  // Dispatch FSM: IDLE picks a lane per packet, LOCKED holds it until din TLAST.
  typedef enum logic {
    DISP_IDLE   = 1'b0,
    DISP_LOCKED = 1'b1
  } disp_state_t;

  // Per-lane in-flight packet counter width (MAX_OUTSTANDING <= 7).
  localparam int CREDIT_W = 3;

endpackage

// File: rtl/axis_cpu_order_fifo.sv
// rtl/axis_cpu_order_fifo.sv - order FIFO holding the lane index of every dispatched packet
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i, din_i    write a lane index (ignored when full)
//   pop_i, dout_o    remove the head entry (ignored when empty); dout_o shows the head
//   full_o, empty_o  registered occupancy flags
module axis_cpu_order_fifo #(
  parameter int WIDTH      = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  empty_q;
  logic                  do_push;
  logic                  do_pop;

  // Push looks only at the registered full flag, so a same-cycle pop never
  // opens room for a push (no pop-to-push combinational path).
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == (DEPTH_LOG2 + 1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/axis_cpu_dispatch.sv
// rtl/axis_cpu_dispatch.sv - round-robin packet dispatcher over N axis_cpu lanes with in-order collection
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   din_T*                       network-side input packet stream
//   cpu_din_T*                   per-lane streams to CPU inputs (TDATA/TLAST broadcast, TVALID per lane)
//   cpu_dout_T*                  per-lane result streams from CPU outputs
//   dout_T*                      network-side output packet stream, in dispatch order
module axis_cpu_dispatch
  import axis_cpu_dispatch_pkg::*;
#(
  parameter int N_CPUS           = 4,
  parameter int IDX_WIDTH        = 2,
  parameter int ORDER_DEPTH_LOG2 = 4,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            din_TDATA,
  input  logic                   din_TVALID,
  output logic                   din_TREADY,
  input  logic                   din_TLAST,
  output logic [32*N_CPUS-1:0]   cpu_din_TDATA,
  output logic [N_CPUS-1:0]      cpu_din_TVALID,
  input  logic [N_CPUS-1:0]      cpu_din_TREADY,
  output logic [N_CPUS-1:0]      cpu_din_TLAST,
  input  logic [32*N_CPUS-1:0]   cpu_dout_TDATA,
  input  logic [N_CPUS-1:0]      cpu_dout_TVALID,
  output logic [N_CPUS-1:0]      cpu_dout_TREADY,
  input  logic [N_CPUS-1:0]      cpu_dout_TLAST,
  output logic [31:0]            dout_TDATA,
  output logic                   dout_TVALID,
  input  logic                   dout_TREADY,
  output logic                   dout_TLAST
);

  disp_state_t                          state_q;
  logic [IDX_WIDTH-1:0]                 sel_lane_q;
  logic [IDX_WIDTH-1:0]                 rr_ptr_q;
  logic [N_CPUS-1:0][CREDIT_W-1:0]      credit_q;
  logic [N_CPUS-1:0][CREDIT_W-1:0]      credit_d;

  logic                 cand_found;
  logic [IDX_WIDTH-1:0] cand_idx;
  logic [IDX_WIDTH-1:0] rr_ptr_d;
  logic [IDX_WIDTH-1:0] disp_lane;
  logic                 route_en;
  logic                 push;
  logic                 pop;
  logic                 din_hs;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IDX_WIDTH-1:0] fifo_head;
  logic [31:0]          lane_dout_data [N_CPUS];

  // Round-robin search starting at rr_ptr for a lane below its credit limit.
  always_comb begin
    int                   j;
    logic [IDX_WIDTH-1:0] lane_j;
    cand_found = 1'b0;
    cand_idx   = '0;
    j          = 0;
    lane_j     = '0;
    for (int k = 0; k < N_CPUS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_CPUS) begin
        j = j - N_CPUS;
      end
      lane_j = IDX_WIDTH'(j);
      if (!cand_found && (credit_q[lane_j] < CREDIT_W'(MAX_OUTSTANDING))) begin
        cand_found = 1'b1;
        cand_idx   = lane_j;
      end
    end
    // No new packet may start unless its lane index can be recorded.
    if (fifo_full) begin
      cand_found = 1'b0;
    end
  end

  assign rr_ptr_d  = (cand_idx == IDX_WIDTH'(N_CPUS - 1)) ? '0 : cand_idx + 1'b1;
  assign disp_lane = (state_q == DISP_LOCKED) ? sel_lane_q : cand_idx;
  assign route_en  = (state_q == DISP_LOCKED) || cand_found;

  // Handshake outputs are forced low during reset even though the state is
  // already cleared, because the idle pool would otherwise look ready.
  assign din_TREADY    = !rst && route_en && cpu_din_TREADY[disp_lane];
  assign din_hs        = din_TVALID && din_TREADY;
  assign push          = din_hs && (state_q == DISP_IDLE);
  assign cpu_din_TDATA = {N_CPUS{din_TDATA}};
  assign cpu_din_TLAST = {N_CPUS{din_TLAST}};

  assign dout_TDATA  = lane_dout_data[fifo_head];
  assign dout_TLAST  = cpu_dout_TLAST[fifo_head];
  assign dout_TVALID = !rst && !fifo_empty && cpu_dout_TVALID[fifo_head];
  assign pop         = dout_TVALID && dout_TREADY && dout_TLAST;

  for (genvar g = 0; g < N_CPUS; g++) begin : g_lane
    logic lane_inc;
    logic lane_dec;

    assign lane_dout_data[g]  = cpu_dout_TDATA[32*g +: 32];
    assign cpu_din_TVALID[g]  = !rst && route_en && (disp_lane == IDX_WIDTH'(g)) && din_TVALID;
    assign cpu_dout_TREADY[g] = !rst && !fifo_empty && (fifo_head == IDX_WIDTH'(g)) && dout_TREADY;

    assign lane_inc = push && (cand_idx == IDX_WIDTH'(g));
    assign lane_dec = pop && (fifo_head == IDX_WIDTH'(g)) && (credit_q[g] != '0);
    // Push and pop on the same lane cancel out.
    assign credit_d[g] = (lane_inc && !lane_dec) ? credit_q[g] + 1'b1 :
                         (lane_dec && !lane_inc) ? credit_q[g] - 1'b1 :
                                                   credit_q[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DISP_IDLE;
      sel_lane_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        DISP_IDLE: begin
          if (push) begin
            rr_ptr_q <= rr_ptr_d;
            if (!din_TLAST) begin
              state_q    <= DISP_LOCKED;
              sel_lane_q <= cand_idx;
            end
          end
        end
        DISP_LOCKED: begin
          if (din_hs && din_TLAST) begin
            state_q <= DISP_IDLE;
          end
        end
        default: state_q <= DISP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  axis_cpu_order_fifo #(
    .WIDTH      (IDX_WIDTH),
    .DEPTH_LOG2 (ORDER_DEPTH_LOG2)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (cand_idx),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A result TLAST from a lane with no packet in flight breaks the contract.
  a_no_credit_underflow : assert property (
    @(posedge clk) disable iff (rst) pop |-> (credit_q[fifo_head] != '0)
  );

endmodule

// File: tb/tb_axis_cpu_dispatch.sv
// tb/tb_axis_cpu_dispatch.sv - directed self-checking bench for axis_cpu_dispatch
module tb_axis_cpu_dispatch;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  din_TDATA;
  logic         din_TVALID;
  logic         din_TREADY;
  logic         din_TLAST;
  logic [127:0] cpu_din_TDATA;
  logic [3:0]   cpu_din_TVALID;
  logic [3:0]   cpu_din_TREADY;
  logic [3:0]   cpu_din_TLAST;
  logic [127:0] cpu_dout_TDATA;
  logic [3:0]   cpu_dout_TVALID;
  logic [3:0]   cpu_dout_TREADY;
  logic [3:0]   cpu_dout_TLAST;
  logic [31:0]  dout_TDATA;
  logic         dout_TVALID;
  logic         dout_TREADY;
  logic         dout_TLAST;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_cpu_dispatch #(
    .N_CPUS           (4),
    .IDX_WIDTH        (2),
    .ORDER_DEPTH_LOG2 (4),
    .MAX_OUTSTANDING  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .din_TDATA       (din_TDATA),
    .din_TVALID      (din_TVALID),
    .din_TREADY      (din_TREADY),
    .din_TLAST       (din_TLAST),
    .cpu_din_TDATA   (cpu_din_TDATA),
    .cpu_din_TVALID  (cpu_din_TVALID),
    .cpu_din_TREADY  (cpu_din_TREADY),
    .cpu_din_TLAST   (cpu_din_TLAST),
    .cpu_dout_TDATA  (cpu_dout_TDATA),
    .cpu_dout_TVALID (cpu_dout_TVALID),
    .cpu_dout_TREADY (cpu_dout_TREADY),
    .cpu_dout_TLAST  (cpu_dout_TLAST),
    .dout_TDATA      (dout_TDATA),
    .dout_TVALID     (dout_TVALID),
    .dout_TREADY     (dout_TREADY),
    .dout_TLAST      (dout_TLAST)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat at the drive point, check routing, then take the edge.
  task automatic send(input logic [31:0] d, input logic last, input int lane, input string tag);
    din_TDATA  = d;
    din_TLAST  = last;
    din_TVALID = 1'b1;
    #1;
    chk({tag, "_vld"}, 32'(cpu_din_TVALID), 32'(1 << lane));
    chk({tag, "_rdy"}, 32'(din_TREADY), 32'd1);
    chk({tag, "_bcast"}, cpu_din_TDATA[127:96], d);
    @(posedge clk); #1;
    din_TVALID = 1'b0;
    din_TLAST  = 1'b0;
  endtask

  // Pop one single-beat result; lane data is 0x200+lane.
  task automatic collect(input int lane, input string tag);
    dout_TREADY = 1'b1;
    #1;
    chk({tag, "_dv"}, 32'(dout_TVALID), 32'd1);
    chk({tag, "_dd"}, dout_TDATA, 32'h200 + 32'(lane));
    chk({tag, "_crdy"}, 32'(cpu_dout_TREADY), 32'(1 << lane));
    @(posedge clk); #1;
    dout_TREADY = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int errs;
    cpu_dout_TDATA  = {32'h203, 32'h202, 32'h201, 32'h200};
    cpu_dout_TLAST  = 4'hF;
    cpu_din_TREADY  = 4'hF;
    cpu_dout_TVALID = 4'hF;
    din_TDATA       = 32'h0;
    din_TLAST       = 1'b1;
    din_TVALID      = 1'b1;
    dout_TREADY     = 1'b1;
    rst             = 1'b1;

    // Reset: every handshake output low despite active inputs.
    #2;
    chk("rst_din_rdy", 32'(din_TREADY), 32'd0);
    chk("rst_cpu_vld", 32'(cpu_din_TVALID), 32'd0);
    chk("rst_cpu_rdy", 32'(cpu_dout_TREADY), 32'd0);
    chk("rst_dout_vld", 32'(dout_TVALID), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    din_TVALID      = 1'b0;
    din_TLAST       = 1'b0;
    cpu_dout_TVALID = 4'h0;
    dout_TREADY     = 1'b0;
    rst             = 1'b0;

    // 1: four single-beat packets go to lanes 0..3 and come back in order.
    for (int p = 0; p < 4; p++) send(32'h100 + 32'(p), 1'b1, p, "t1");
    cpu_dout_TVALID = 4'hF;
    for (int k = 0; k < 4; k++) collect(k, "t1c");
    dout_TREADY = 1'b1;
    #1;
    chk("t1_empty_dv", 32'(dout_TVALID), 32'd0);
    chk("t1_empty_rdy", 32'(cpu_dout_TREADY), 32'd0);
    @(posedge clk); #1;
    dout_TREADY     = 1'b0;
    cpu_dout_TVALID = 4'h0;

    // 2: lane 1 result late; lanes 2/3 ready early must wait behind it.
    for (int p = 0; p < 4; p++) send(32'h110 + 32'(p), 1'b1, p, "t2");
    cpu_dout_TVALID = 4'b1101;
    collect(0, "t2c0");
    dout_TREADY = 1'b1;
    errs = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (dout_TVALID !== 1'b0 || cpu_dout_TREADY !== 4'b0010) errs++;
      @(posedge clk); #1;
    end
    chk("t2_stall", 32'(errs), 32'd0);
    dout_TREADY     = 1'b0;
    cpu_dout_TVALID = 4'hF;
    for (int k = 1; k < 4; k++) collect(k, "t2c");
    cpu_dout_TVALID = 4'h0;

    // 3: credit limit of 2 per lane; the 9th packet waits for a result TLAST.
    for (int p = 0; p < 8; p++) send(32'h300 + 32'(p), 1'b1, p % 4, "t3");
    din_TDATA  = 32'h308;
    din_TLAST  = 1'b1;
    din_TVALID = 1'b1;
    #1;
    chk("t3_full_rdy", 32'(din_TREADY), 32'd0);
    chk("t3_full_vld", 32'(cpu_din_TVALID), 32'd0);
    @(posedge clk); #1;
    chk("t3_full_rdy2", 32'(din_TREADY), 32'd0);
    cpu_dout_TVALID = 4'b0001;
    dout_TREADY     = 1'b1;
    #1;
    chk("t3_pop_rdy", 32'(din_TREADY), 32'd0);
    chk("t3_pop_crdy", 32'(cpu_dout_TREADY), 32'h1);
    @(posedge clk); #1;
    dout_TREADY     = 1'b0;
    cpu_dout_TVALID = 4'h0;
    #1;
    chk("t3_freed_rdy", 32'(din_TREADY), 32'd1);
    chk("t3_freed_vld", 32'(cpu_din_TVALID), 32'h1);
    @(posedge clk); #1;
    din_TVALID = 1'b0;
    din_TLAST  = 1'b0;
    cpu_dout_TVALID = 4'hF;
    for (int k = 0; k < 8; k++) collect((k + 1) % 4, "t3c");
    cpu_dout_TVALID = 4'h0;

    // 4: 5-beat packet locked to lane 2 with a 3-cycle lane stall.
    send(32'h3ff, 1'b1, 1, "t4pre");
    send(32'h400, 1'b0, 2, "t4b0");
    send(32'h401, 1'b0, 2, "t4b1");
    din_TDATA      = 32'h402;
    din_TVALID     = 1'b1;
    cpu_din_TREADY = 4'b1011;
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (din_TREADY !== 1'b0 || cpu_din_TVALID !== 4'b0100) errs++;
      @(posedge clk); #1;
    end
    chk("t4_stall", 32'(errs), 32'd0);
    cpu_din_TREADY = 4'hF;
    send(32'h402, 1'b0, 2, "t4b2");
    send(32'h403, 1'b0, 2, "t4b3");
    send(32'h404, 1'b1, 2, "t4b4");
    send(32'h500, 1'b1, 3, "t4idle");
    cpu_dout_TVALID = 4'hF;
    for (int k = 1; k < 4; k++) collect(k, "t4c");
    cpu_dout_TVALID = 4'h0;

    // 5: push and pop of lane 0 in the same cycle.
    for (int p = 0; p < 4; p++) send(32'h600 + 32'(p), 1'b1, p, "t5");
    din_TDATA       = 32'h604;
    din_TLAST       = 1'b1;
    din_TVALID      = 1'b1;
    cpu_dout_TVALID = 4'b0001;
    dout_TREADY     = 1'b1;
    #1;
    chk("t5_both_rdy", 32'(din_TREADY), 32'd1);
    chk("t5_both_vld", 32'(cpu_din_TVALID), 32'h1);
    chk("t5_both_crdy", 32'(cpu_dout_TREADY), 32'h1);
    chk("t5_both_dv", 32'(dout_TVALID), 32'd1);
    @(posedge clk); #1;
    din_TVALID      = 1'b0;
    din_TLAST       = 1'b0;
    dout_TREADY     = 1'b0;
    cpu_dout_TVALID = 4'h0;
    // Lane 0 at credit 1 accepts exactly one more; then all lanes are full.
    for (int p = 0; p < 4; p++) send(32'h610 + 32'(p), 1'b1, (p + 1) % 4, "t5b");
    din_TVALID = 1'b1;
    din_TLAST  = 1'b1;
    #1;
    chk("t5_full_rdy", 32'(din_TREADY), 32'd0);
    @(posedge clk); #1;
    din_TVALID = 1'b0;
    din_TLAST  = 1'b0;
    cpu_dout_TVALID = 4'hF;
    for (int k = 0; k < 8; k++) collect((k + 1) % 4, "t5c");
    dout_TREADY = 1'b1;
    #1;
    chk("t5_drained", 32'(dout_TVALID), 32'd0);
    @(posedge clk); #1;
    dout_TREADY     = 1'b0;
    cpu_dout_TVALID = 4'h0;

    // 6: reset while locked on lane 1.
    send(32'h700, 1'b0, 1, "t6b0");
    din_TDATA       = 32'h701;
    din_TVALID      = 1'b1;
    cpu_dout_TVALID = 4'hF;
    dout_TREADY     = 1'b1;
    #1;
    chk("t6_pre_rdy", 32'(din_TREADY), 32'd1);
    chk("t6_pre_dv", 32'(dout_TVALID), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_din_rdy", 32'(din_TREADY), 32'd0);
    chk("t6_rst_cpu_vld", 32'(cpu_din_TVALID), 32'd0);
    chk("t6_rst_cpu_rdy", 32'(cpu_dout_TREADY), 32'd0);
    chk("t6_rst_dout_vld", 32'(dout_TVALID), 32'd0);
    @(posedge clk); #1;
    din_TVALID      = 1'b0;
    cpu_dout_TVALID = 4'h0;
    dout_TREADY     = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'h800, 1'b1, 0, "t6post");
    cpu_dout_TVALID = 4'hF;
    collect(0, "t6c");
    cpu_dout_TVALID = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
